move_replay: RTL
================

// Module: move_replay
// PURPOSE
//  Drives move requests into the play logic. It is the sending end of the 4-bit one-hot act-flag
//  interface that play consumes.
//  Records every accepted player move during GAMING into a move buffer. On request, replays the
//  buffer as one-cycle one-hot act pulses. Its output is ORed with the button flags upstream of play.
//  Sits beside the button flag generators in the game-control top; clocked on clk_d.
// PARAMETERS
//  DEPTH      64  moves held in buffer (power of 2, >=4)
//  PULSE_GAP  4   idle clk_d cycles between replayed pulses (>=1)
// PORTS
//  clk_d        in   1   game clock; sole clock of the block
//  rst          in   1   synchronous, active-high reset
//  game_status  in   2   00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED
//  act_flag     in   4   one-cycle button move pulses (from button flag generators)
//  replay_sw    in   1   level switch; rising edge requests replay
//  clear        in   1   one-cycle pulse: empty the buffer
//  replay_act   out  4   one-hot one-cycle replayed move pulse; 0 when idle
//  replaying    out  1   high while replay FSM is not IDLE
//  move_count   out  $clog2(DEPTH)+1  moves stored
//  full         out  1   move_count==DEPTH
//  overflow     out  1   sticky: a move was dropped because the buffer was full
// BEHAVIOUR
//  Reset: replay_act=0, replaying=0, move_count=0, full=0, overflow=0, FSM=IDLE, replay_sw edge register=0.
//  Move encoding: 2-bit index of the act bit. If several act_flag bits are high in one cycle, record the lowest index only.
//  Recording: in IDLE with game_status==01 and act_flag!=0:
//   - write the move at index move_count; move_count+1 next cycle.
//   - when full, drop the move and set overflow.
//   - act_flag is never recorded while replaying.
//  Clearing:
//   - clear in IDLE -> move_count=0 and overflow=0 next cycle.
//   - game_status==10 (GAME_INITIAL), in any state, forces the same clear and FSM=IDLE.
//   - clear during replay is ignored.
//   - clear and act_flag in the same cycle: clear wins; the move is not stored.
//  FSM: IDLE -> PULSE -> GAP -> PULSE ... -> IDLE.
//   - IDLE->PULSE on a replay_sw rising edge (registered compare), game_status==01 and move_count>0. Read index rd=0.
//   - PULSE: replay_act=onehot(buf[rd]) for exactly 1 cycle. rd+1. Go to GAP.
//   - GAP: PULSE_GAP cycles with replay_act=0. Then PULSE if rd<move_count, else IDLE.
//   - Latency: first pulse appears 1 cycle after the edge is detected.
//   - A full replay of N moves spans N*(PULSE_GAP+1) cycles.
//  Abort: game_status!=01 in PULSE or GAP -> IDLE next cycle, and replay_act=0 in that same cycle (combinationally gated).
//  Buffer retention: buffer and move_count are kept after replay, so replaying again repeats the moves.
//   - replay_sw edge while replaying is ignored.
//  Width rules: move_count saturates at DEPTH; rd wraps never (bounded by move_count).
// CONFIGURATION
//  UNDO_EN defined:
//   - adds input undo_bt (1, one-cycle pulse).
//   - undo_bt in IDLE, with GAMING and move_count>0: emit onehot(buf[move_count-1]) on replay_act for 1 cycle, then move_count-1.
//   - Moves toggle, so re-applying a move undoes it.
//   - undo_bt and act_flag in the same cycle: undo wins; the move is not recorded.
//   - undo_bt with move_count==0: no action.
//  UNDO_EN undefined: no undo_bt port; no undo logic.
// STRUCTURE
//  game_pkg: status codes (CHOSE_BOARD, GAMING, GAME_INITIAL, WINNED), move encode/decode functions, FSM state codes.
//  Sub-module move_ram: DEPTH x 2-bit synchronous-write, asynchronous-read buffer (wr_en, wr_addr, wr_data, rd_addr).
//  move_replay holds the FSM, counters, gap timer and edge detect.
// TESTING
//  1. GAMING; act_flag 0001,0100,1000,0010 -> move_count=4. replay_sw 0->1 -> replay_act 0001,0100,1000,0010, each 1 cycle, 4 zero cycles between; then replaying=0.
//  2. DEPTH=64: 65 moves -> move_count=64, full=1, overflow=1. clear -> count 0, full 0, overflow 0.
//  3. Mid-replay (after 2nd pulse) game_status->11 -> replay_act=0 that cycle, replaying=0 next cycle, move_count unchanged.
//  4. act_flag=0110 -> stored move is index 1; replay emits 0010. act_flag during replay -> move_count unchanged.
//  5. game_status->10 with move_count=7 -> move_count=0 next cycle. replay_sw edge with count 0 -> replaying stays 0.
//  6. UNDO_EN: moves 0001,1000; undo_bt -> replay_act=1000 one cycle, move_count=1. Second undo -> 0001, count 0. Third undo -> nothing.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game status codes, replay FSM states and move encode/decode helpers
//
// Contents:
//   CHOSE_BOARD, GAMING, GAME_INITIAL, WINNED : 2-bit game_status codes
//   S_IDLE, S_PULSE, S_GAP                    : move_replay FSM state codes
//   encode_move : one-hot act flags -> 2-bit index of the lowest set bit
//   decode_move : 2-bit move index  -> one-hot act flags
package game_pkg;

  localparam logic [1:0] CHOSE_BOARD  = 2'b00;
  localparam logic [1:0] GAMING       = 2'b01;
  localparam logic [1:0] GAME_INITIAL = 2'b10;
  localparam logic [1:0] WINNED       = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // Several simultaneous flags record only the lowest index.
  function automatic logic [1:0] encode_move(input logic [3:0] act);
    if (act[0])      return 2'd0;
    else if (act[1]) return 2'd1;
    else if (act[2]) return 2'd2;
    else             return 2'd3;
  endfunction

  function automatic logic [3:0] decode_move(input logic [1:0] mv);
    return 4'b0001 << mv;
  endfunction

endpackage

// File: rtl/move_ram.sv
// rtl/move_ram.sv - DEPTH x 2-bit move buffer, synchronous write, asynchronous read
//
// Ports:
//   clk     in  1       write clock
//   wr_en   in  1       write strobe
//   wr_addr in  AW      write address
//   wr_data in  2       encoded move to store
//   rd_addr in  AW      read address
//   rd_data out 2       combinational read of mem[rd_addr]
module move_ram
  import game_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_data
);

  logic [1:0] mem [DEPTH];

  // No reset: contents are only meaningful below move_count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/move_replay.sv
// rtl/move_replay.sv - records player moves during GAMING and replays them as one-hot act pulses
//
// Optional feature macro: UNDO_EN (adds undo_bt input and undo pulse logic).
// Ports:
//   clk_d       in  1      game clock
//   rst         in  1      synchronous active-high reset
//   game_status in  2      00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED
//   act_flag    in  4      one-cycle button move pulses
//   replay_sw   in  1      level switch, rising edge requests replay
//   clear       in  1      one-cycle pulse, empties the buffer when idle
//   undo_bt     in  1      (UNDO_EN only) one-cycle undo request
//   replay_act  out 4      one-hot replayed (or undo) move pulse, 0 when idle
//   replaying   out 1      FSM not idle
//   move_count  out CW     number of stored moves
//   full        out 1      move_count == DEPTH
//   overflow    out 1      sticky, a move was dropped while full
module move_replay
  import game_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int PULSE_GAP = 4
) (
  input  logic                    clk_d,
  input  logic                    rst,
  input  logic [1:0]              game_status,
  input  logic [3:0]              act_flag,
  input  logic                    replay_sw,
  input  logic                    clear,
`ifdef UNDO_EN
  input  logic                    undo_bt,
`endif
  output logic [3:0]              replay_act,
  output logic                    replaying,
  output logic [$clog2(DEPTH):0]  move_count,
  output logic                    full,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(PULSE_GAP - 1);

  logic [1:0]    state;
  logic [CW-1:0] rd;
  logic [GW-1:0] gap_cnt;
  logic          sw_q;

  logic          gaming;
  logic          initial_st;
  logic          idle;
  logic          sw_rise;
  logic          rec_req;
  logic          start;
  logic          undo_go;
  logic          wr_en;
  logic [AW-1:0] ram_rd_addr;
  logic [1:0]    ram_rd_data;
  logic [3:0]    pulse_act;

  assign gaming     = (game_status == GAMING);
  assign initial_st = (game_status == GAME_INITIAL);
  assign idle       = (state == S_IDLE);
  assign sw_rise    = replay_sw & ~sw_q;
  assign rec_req    = gaming && (act_flag != 4'b0000);
  assign start      = sw_rise && gaming && (move_count != '0);
  assign full       = (move_count == CW'(DEPTH));
  assign replaying  = !idle;

`ifdef UNDO_EN
  logic [AW-1:0] last_addr;
  logic [3:0]    undo_act;

  assign last_addr = move_count[AW-1:0] - AW'(1);
  assign undo_go   = idle && !clear && undo_bt && gaming && (move_count != '0);
  // While idle the read port serves undo; while replaying it serves rd.
  assign ram_rd_addr = idle ? last_addr : rd[AW-1:0];

  always_ff @(posedge clk_d) begin
    if (rst || initial_st) undo_act <= 4'b0000;
    else if (undo_go)      undo_act <= decode_move(ram_rd_data);
    else                   undo_act <= 4'b0000;
  end
`else
  assign undo_go     = 1'b0;
  assign ram_rd_addr = rd[AW-1:0];
`endif

  // Clear and undo both win over a same-cycle move.
  assign wr_en = idle && !initial_st && !clear && !undo_go && rec_req && !full;

  move_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk_d),
    .wr_en   (wr_en),
    .wr_addr (move_count[AW-1:0]),
    .wr_data (encode_move(act_flag)),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // Pulse is gated by the live status so an abort silences it immediately.
  assign pulse_act = (state == S_PULSE && gaming) ? decode_move(ram_rd_data) : 4'b0000;

`ifdef UNDO_EN
  assign replay_act = pulse_act | undo_act;
`else
  assign replay_act = pulse_act;
`endif

  always_ff @(posedge clk_d) begin
    if (rst) begin
      state      <= S_IDLE;
      rd         <= '0;
      gap_cnt    <= '0;
      sw_q       <= 1'b0;
      move_count <= '0;
      overflow   <= 1'b0;
    end else begin
      sw_q <= replay_sw;
      if (initial_st) begin
        move_count <= '0;
        overflow   <= 1'b0;
        state      <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (clear) begin
              move_count <= '0;
              overflow   <= 1'b0;
            end else if (undo_go) begin
              move_count <= move_count - CW'(1);
            end else begin
              if (rec_req) begin
                if (full) overflow   <= 1'b1;
                else      move_count <= move_count + CW'(1);
              end
              if (start) begin
                state <= S_PULSE;
                rd    <= '0;
              end
            end
          end
          S_PULSE: begin
            if (!gaming) begin
              state <= S_IDLE;
            end else begin
              rd      <= rd + CW'(1);
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end
          S_GAP: begin
            if (!gaming) begin
              state <= S_IDLE;
            end else if (gap_cnt == GAP_LAST) begin
              state <= (rd < move_count) ? S_PULSE : S_IDLE;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
